// File: rtl/mc_controller.sv
// mc_controller -- multicycle processor control FSM (Moore style).
//
// Walks each instruction through FETCH -> DECODE -> execute/memory states and
// drives the datapath selects, write enables and memory handshake.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   op, funct, rd            latched instruction fields
//   cond_ex                  condition check passed for current instruction
//   mem_ready                memory accepts/completes the current access
//   ir_write, pc_write       IR / PC load enables
//   reg_write, mem_write     register file / data memory write enables
//   mem_req, adr_src         memory request and address select (0 PC, 1 ALU)
//   alu_src_a, alu_src_b     ALU operand selects
//   result_src, alu_op       result select, ALU decoder enable
//   illegal, retire          one-cycle event pulses
//   state                    current state code (debug)
//
// Build option: define MC_MEM_WAIT_EN to honour mem_ready wait states in
// FETCH, MEMRD and MEMWR. Without it every access completes in one cycle.
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       mem_req,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  state_e state_q, state_d;
  logic   rdy;
  logic   ir_w, pc_w, rw_w, mw_w, ill_w, ret_w;
  logic   unused_bits;

`ifdef MC_MEM_WAIT_EN
  assign rdy = mem_ready;
  assign unused_bits = ^funct[2:1];
`else
  // Zero-wait memory: every access is accepted in the cycle it is requested.
  assign rdy = 1'b1;
  assign unused_bits = ^{funct[2:1], mem_ready};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    rw_w       = 1'b0;
    mw_w       = 1'b0;
    ill_w      = 1'b0;
    ret_w      = 1'b0;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // ALU computes PC+4 in parallel with the instruction read.
        mem_req    = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (rdy) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: ill_w   = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        rw_w       = cond_ex;
        ret_w      = 1'b1;
      end
      S_MEMWR: begin
        // A failed condition skips the bus entirely and retires at once.
        if (cond_ex) begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          mw_w    = rdy;
          ret_w   = rdy;
          state_d = rdy ? S_FETCH : S_MEMWR;
        end else begin
          ret_w = 1'b1;
        end
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        // funct[4:3]=10 are the compare/test ops: flags only, no writeback.
        rw_w  = cond_ex & (funct[4:3] != 2'b10);
        pc_w  = cond_ex & (funct[4:3] != 2'b10) & (rd == 4'hF);
        ret_w = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w       = cond_ex;
        ret_w      = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked while reset is held so nothing commits mid-reset.
  assign ir_write  = ir_w  & reset_n;
  assign pc_write  = pc_w  & reset_n;
  assign reg_write = rw_w  & reset_n;
  assign mem_write = mw_w  & reset_n;
  assign illegal   = ill_w & reset_n;
  assign retire    = ret_w & reset_n;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. A per-instruction reference model
// expands each instruction into its expected cycle-by-cycle trace (state code,
// mem_ready to drive, outputs), which is then replayed against the DUT.
module tb_mc_controller;
`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] rd = 4'b0;
  logic       cond_ex = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write, reg_write, mem_write, mem_req, adr_src;
  logic       alu_src_a, alu_op, illegal, retire;
  logic [1:0] alu_src_b, result_src;
  logic [3:0] state;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd),
    .cond_ex(cond_ex), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
    .mem_req(mem_req), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .illegal(illegal), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir, pc, rw, mw, mreq, adr, asa;
    logic [1:0] asb, rs;
    logic       aop, ill, ret;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    outs_t      o;
  } cyc_t;

  cyc_t  q[$];
  int    ncmp = 0;
  int    nfail = 0;
  outs_t obs;
  logic [5:0] strobes;

  assign obs = {ir_write, pc_write, reg_write, mem_write, mem_req, adr_src,
                alu_src_a, alu_src_b, result_src, alu_op, illegal, retire};
  assign strobes = {ir_write, pc_write, reg_write, mem_write, retire, illegal};

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // mem_ready on an access's completing cycle: must be 1 when waits are
  // honoured, anything at all when they are not.
  function automatic logic acc();
    return WAIT_EN ? 1'b1 : rnd();
  endfunction

  function automatic void push(logic [3:0] st, logic rdy, outs_t o);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.o = o;
    q.push_back(c);
  endfunction

  // Expected trace of one instruction; sf/sm = wait cycles on fetch / data access.
  function automatic void build(logic [1:0] op_, logic [5:0] fn, logic [3:0] rd_,
                                logic c, int sf, int sm);
    outs_t o;
    int nf, nm;
    nf = WAIT_EN ? sf : 0;
    nm = WAIT_EN ? sm : 0;
    o = '0; o.mreq = 1'b1; o.asa = 1'b1; o.asb = 2'b10; o.rs = 2'b10;
    for (int i = 0; i < nf; i++) push(4'd0, 1'b0, o);
    o.ir = 1'b1; o.pc = 1'b1;
    push(4'd0, acc(), o);
    o = '0; o.asa = 1'b1; o.asb = 2'b10; o.rs = 2'b10; o.ill = (op_ == 2'b11);
    push(4'd1, rnd(), o);
    case (op_)
      2'b00: begin
        o = '0; o.asb = fn[5] ? 2'b01 : 2'b00; o.aop = 1'b1;
        push(fn[5] ? 4'd7 : 4'd6, rnd(), o);
        o = '0; o.rw = c && (fn[4:3] != 2'b10); o.pc = o.rw && (rd_ == 4'd15);
        o.ret = 1'b1;
        push(4'd8, rnd(), o);
      end
      2'b01: begin
        o = '0; o.asb = 2'b01;
        push(4'd2, rnd(), o);
        if (fn[0]) begin
          o = '0; o.mreq = 1'b1; o.adr = 1'b1;
          for (int i = 0; i < nm; i++) push(4'd3, 1'b0, o);
          push(4'd3, acc(), o);
          o = '0; o.rs = 2'b01; o.rw = c; o.ret = 1'b1;
          push(4'd4, rnd(), o);
        end else if (c) begin
          o = '0; o.mreq = 1'b1; o.adr = 1'b1;
          for (int i = 0; i < nm; i++) push(4'd5, 1'b0, o);
          o.mw = 1'b1; o.ret = 1'b1;
          push(4'd5, acc(), o);
        end else begin
          o = '0; o.ret = 1'b1;
          push(4'd5, rnd(), o);
        end
      end
      2'b10: begin
        o = '0; o.asb = 2'b01; o.rs = 2'b10; o.pc = c; o.ret = 1'b1;
        push(4'd9, rnd(), o);
      end
      default: ;
    endcase
  endfunction

  task automatic run(input string tag, input int maxn);
    cyc_t c;
    int   n;
    n = 0;
    while (q.size() > 0 && n < maxn) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      #2;
      ncmp++;
      assert (state === c.st) else begin
        nfail++;
        $error("FAIL %s[%0d] state: got %0d want %0d", tag, n, state, c.st);
      end
      ncmp++;
      assert (obs === c.o) else begin
        nfail++;
        $error("FAIL %s[%0d] outputs: got %h want %h", tag, n, obs, c.o);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_instr(input string tag, input logic [1:0] o_, input logic [5:0] f,
                          input logic [3:0] r, input logic c, input int sf, input int sm);
    op = o_; funct = f; rd = r; cond_ex = c;
    build(o_, f, r, c, sf, sm);
    run(tag, 1000);
  endtask

  initial begin
    // Power-on reset, two cycles; FETCH with mem_ready=1 must not strobe.
    reset_n = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ncmp++;
    assert (state === 4'd0) else begin
      nfail++; $error("FAIL rst_state: got %0d want 0", state);
    end
    ncmp++;
    assert (strobes === 6'b0) else begin
      nfail++; $error("FAIL rst_strobes: got %b want 000000", strobes);
    end
    reset_n = 1'b1;

    // Directed instructions.
    do_instr("add",     2'b00, 6'b001000, 4'd3,  1'b1, 0, 0);
    do_instr("ldr",     2'b01, 6'b011001, 4'd2,  1'b1, 0, 2);
    do_instr("str_nc",  2'b01, 6'b011000, 4'd2,  1'b0, 0, 0);
    do_instr("str",     2'b01, 6'b011000, 4'd5,  1'b1, 1, 1);
    do_instr("cmp",     2'b00, 6'b010101, 4'd0,  1'b1, 0, 0);
    do_instr("mov_pc",  2'b00, 6'b011010, 4'd15, 1'b1, 0, 0);
    do_instr("movi_nc", 2'b00, 6'b111010, 4'd15, 1'b0, 2, 0);
    do_instr("illegal", 2'b11, 6'b000000, 4'd0,  1'b1, 0, 0);
    do_instr("b_nc",    2'b10, 6'b000000, 4'd0,  1'b0, 0, 0);
    do_instr("b",       2'b10, 6'b000000, 4'd0,  1'b1, 1, 0);

    // Reset in the middle of a load's MEMRD access.
    op = 2'b01; funct = 6'b011001; rd = 4'd4; cond_ex = 1'b1;
    build(2'b01, 6'b011001, 4'd4, 1'b1, 0, 0);
    run("ldr_pre", 3);
    q.delete();
    mem_ready = 1'b0; reset_n = 1'b0;
    #2;
    ncmp++;
    assert (state === 4'd3) else begin
      nfail++; $error("FAIL midrst_pre_state: got %0d want 3", state);
    end
    ncmp++;
    assert (strobes === 6'b0) else begin
      nfail++; $error("FAIL midrst_strobes_a: got %b want 000000", strobes);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    ncmp++;
    assert (state === 4'd0) else begin
      nfail++; $error("FAIL midrst_state: got %0d want 0", state);
    end
    ncmp++;
    assert (strobes === 6'b0) else begin
      nfail++; $error("FAIL midrst_strobes_b: got %b want 000000", strobes);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    // First cycle after release: fetch requested with mem_ready low.
    do_instr("add_post_rst", 2'b00, 6'b001000, 4'd3, 1'b1, 1, 0);

    // Randomized instruction stream.
    for (int k = 0; k < 80; k++) begin
      do_instr($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
               4'($urandom_range(0, 15)), rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    #2;
    ncmp++;
    assert (state === 4'd0) else begin
      nfail++; $error("FAIL end_state: got %0d want 0", state);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
